// File: rtl/sign_pkg.sv
// Shared types and defaults for the sign decoder slice.
// Holds the buffer state encoding and the buffered entry layout.
package sign_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic sign;
    logic err;
  } entry_t;

endpackage

// File: rtl/sign_skid_buffer.sv
// Two-entry FIFO of decoded sign entries.
// Input ready comes from state only, never from the consumer.
module sign_skid_buffer
  import sign_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  entry_t in_data,
  output logic   in_ready,
  output logic   out_valid,
  output entry_t out_data,
  input  logic   out_ready
);

  state_t state, state_nx;
  entry_t head, tail;
  logic   push, pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        EMPTY: if (push) head <= in_data;
        ONE: begin
          if (push && pop) head <= in_data;
          else if (push)   tail <= in_data;
        end
        FULL: if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)      state_nx = FULL;
        else if (pop && !push) state_nx = EMPTY;
      end
      FULL: if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state == ONE) || (state == FULL);
    out_data  = out_valid ? head : '0;
  end

endmodule

// File: rtl/sign_decoder.sv
// Sign word decoder: flags malformed words, buffers entries,
// and keeps a saturating count of malformed words accepted.
module sign_decoder
  import sign_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_word,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_sign,
  output logic             out_err,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  entry_t in_ent, out_ent;
  logic   push;

  assign in_ent.sign = in_word[0];
  assign in_ent.err  = |in_word[WIDTH-1:1];
  assign push        = in_valid && in_ready;

  sign_skid_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_ent),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_ent),
    .out_ready (out_ready)
  );

  assign out_sign = out_ent.sign;
  assign out_err  = out_ent.err;

  // clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || err_clr)
      err_count <= '0;
    else if (push && in_ent.err && (err_count != '1))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: doc/sign_decoder.md
SIGN_DECODER -- requirements
Module: sign_decoder

Interface
REQ-001 Parameter WIDTH, default 8, meaning width of the encoded sign word (bit 0 = sign, bits WIDTH-1:1 must be zero).
REQ-002 Parameter CNT_W, default 8, meaning width of the saturating error counter.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  encoded word present on in_word.
REQ-007 in_word  input  WIDTH  encoded sign word.
REQ-008 in_ready  output  1  block can accept in_word this cycle.
REQ-009 out_valid  output  1  decoded entry present on out_sign/out_err.
REQ-010 out_sign  output  1  recovered sign bit (in_word[0] of the entry).
REQ-011 out_err  output  1  entry's upper bits were nonzero (malformed word).
REQ-012 out_ready  input  1  consumer takes the head entry this cycle.
REQ-013 err_count  output  CNT_W  number of malformed words accepted since reset/clear, saturating.
REQ-014 err_clr  input  1  single-cycle request to zero err_count.

Function
REQ-015 Buffer SHALL be 2 entries deep, FSM states EMPTY, ONE, FULL; each entry holds {sign, err}.
REQ-016 in_ready SHALL equal 1 in EMPTY and ONE, 0 in FULL; in_ready SHALL be a registered/state-derived signal, not dependent on out_ready combinationally.
REQ-017 Push SHALL occur when in_valid && in_ready; entry sign = in_word[0], err = OR of in_word[WIDTH-1:1].
REQ-018 out_valid SHALL equal 1 in ONE and FULL; out_sign/out_err SHALL show the oldest entry; pop SHALL occur when out_valid && out_ready.
REQ-019 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE (new entry becomes head next cycle); FULL+pop->ONE; FULL with in_valid and no pop->FULL, word not accepted; all others hold.
REQ-020 Latency: an entry pushed in cycle N SHALL be visible on outputs in cycle N+1 if the buffer was EMPTY at N.
REQ-021 Order SHALL be strictly first-in first-out; no entry dropped or duplicated.
REQ-022 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-023 err_count SHALL increment by 1 on each push with err=1, saturating at 2^CNT_W-1 (no wrap).
REQ-024 err_clr SHALL zero err_count next cycle and takes priority over a simultaneous increment (result 0).
REQ-025 out_sign/out_err SHALL be 0 whenever out_valid=0.

Reset
REQ-026 On rst=1 at a clock edge: state EMPTY, in_ready=1, out_valid=0, out_sign=0, out_err=0, err_count=0.
REQ-027 Reset mid-operation SHALL discard all buffered entries; words presented during the reset cycle SHALL not be accepted.
REQ-028 rst SHALL take priority over push, pop and err_clr.

Structure
REQ-029 Shared package sign_pkg SHALL hold WIDTH/CNT_W defaults and the EMPTY/ONE/FULL state encodings (2-bit).
REQ-030 The 2-entry storage plus FSM SHALL be one sub-module, sign_skid_buffer; sign_decoder contains the decode logic and error counter.

Verification
REQ-031 Reset then in_word=8'h01, in_valid=1 one cycle, out_ready=1 -> next cycle out_valid=1, out_sign=1, out_err=0; err_count=0.
REQ-032 out_ready=0, push 8'h00 then 8'h01 -> FULL, in_ready=0; third word 8'h01 not accepted; then out_ready=1 -> outputs sign 0, then 1, then out_valid=0.
REQ-033 Push 8'h81 -> out_sign=1, out_err=1, err_count=1; push 8'h02 -> out_sign=0, out_err=1, err_count=2.
REQ-034 CNT_W=2, push 5 malformed words (8'hFE) -> err_count 1,2,3,3,3; err_clr with a concurrent malformed push -> err_count=0.
REQ-035 In ONE, assert in_valid and out_ready together for 10 cycles with alternating 8'h00/8'h01 -> state stays ONE, output sequence matches input order delayed one cycle.
REQ-036 In FULL, assert rst one cycle with in_valid=1 -> next cycle EMPTY, out_valid=0, err_count=0, in_ready=1.
